// File: rtl/seg_scan_driver.sv
// Four-digit time-multiplexed seven-segment driver. It latches the display word once per
// frame and scans active-low anodes with an optional blank gap at the start of each slot.
module seg_scan_driver #(
  parameter int DIV_N   = 100000,
  parameter int BLANK_N = 1000
) (
  input  logic        SYS_CLK,
  input  logic        RST,
  input  logic [15:0] data_in,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  en_in,
  output logic [3:0]  ctrlBits,
  output logic [7:0]  dispcode,
  output logic        frame_start
);

  localparam int               CNT_W    = $clog2(DIV_N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_N - 1);

  // Active-low segments {g,f,e,d,c,b,a}; the decimal point is added separately.
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    seg7 = 7'h7F;
    case (nib)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      4'hF: seg7 = 7'h0E;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      data_sh_q, data_sh_d;
  logic [3:0]       dp_sh_q, dp_sh_d;
  logic [3:0]       en_sh_q, en_sh_d;
  logic [3:0]       ctrl_bits_q, ctrl_bits_d;
  logic [7:0]       disp_code_q, disp_code_d;
  logic             frame_start_q, frame_start_d;

  logic             cnt_wrap;
  logic             frame_end;
  logic             blank;
  logic [3:0]       nibble;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    cnt_wrap  = (cnt_q == CNT_LAST);
    frame_end = cnt_wrap && (idx_q == 2'd3);

    cnt_d = cnt_wrap ? '0 : cnt_q + CNT_W'(1);
    idx_d = cnt_wrap ? idx_q + 2'd1 : idx_q;

    // Shadows move only at the frame boundary, so a frame never mixes two input words.
    data_sh_d = frame_end ? data_in : data_sh_q;
    dp_sh_d   = frame_end ? dp_in   : dp_sh_q;
    en_sh_d   = frame_end ? en_in   : en_sh_q;

    nibble = data_sh_q[{idx_q, 2'b00} +: 4];
    blank  = (int'(cnt_q) < BLANK_N) || !en_sh_q[idx_q];

    ctrl_bits_d = 4'hF;
    disp_code_d = 8'hFF;
    if (!blank) begin
      ctrl_bits_d = ~(4'b0001 << idx_q);
      disp_code_d = {~dp_sh_q[idx_q], seg7(nibble)};
    end

    frame_start_d = frame_end;
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) begin
      cnt_q         <= '0;
      idx_q         <= 2'd0;
      // NOTE: the shadows are reset on purpose: zero enables make the first frame dark.
      data_sh_q     <= 16'h0000;
      dp_sh_q       <= 4'h0;
      en_sh_q       <= 4'h0;
      ctrl_bits_q   <= 4'hF;
      disp_code_q   <= 8'hFF;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      data_sh_q     <= data_sh_d;
      dp_sh_q       <= dp_sh_d;
      en_sh_q       <= en_sh_d;
      ctrl_bits_q   <= ctrl_bits_d;
      disp_code_q   <= disp_code_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign ctrlBits    = ctrl_bits_q;
  assign dispcode    = disp_code_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: a frame-level timeline model predicts every output
// cycle of a blanked (BLANK_N=2) and an unblanked (BLANK_N=0) instance.
`timescale 1ns/1ps
module tb_seg_scan_driver;

  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int FRAME = 4 * DIV;

  localparam logic [7:0] SEG [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  typedef struct packed {
    logic [3:0] ctrl;
    logic [7:0] disp;
    logic       fs;
  } out_t;

  typedef struct {
    out_t a;
    out_t b;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic [3:0]  en_in;
  logic [3:0]  ctrl_a, ctrl_b;
  logic [7:0]  disp_a, disp_b;
  logic        fs_a, fs_b;

  int total = 0;
  int bad   = 0;

  exp_t        sb_q[$];
  int          k_ref;
  logic [15:0] sh_data;
  logic [3:0]  sh_dp;
  logic [3:0]  sh_en;

  seg_scan_driver #(.DIV_N(DIV), .BLANK_N(BLANK)) dut (
    .SYS_CLK(clk), .RST(rst_n), .data_in(data_in), .dp_in(dp_in), .en_in(en_in),
    .ctrlBits(ctrl_a), .dispcode(disp_a), .frame_start(fs_a)
  );

  seg_scan_driver #(.DIV_N(DIV), .BLANK_N(0)) dut_nb (
    .SYS_CLK(clk), .RST(rst_n), .data_in(data_in), .dp_in(dp_in), .en_in(en_in),
    .ctrlBits(ctrl_b), .dispcode(disp_b), .frame_start(fs_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Output of the display for state-time t since release, from the frame's latched inputs.
  function automatic out_t ref_out(input int t, input logic [15:0] d, input logic [3:0] dp,
                                   input logic [3:0] en, input int blank);
    int   slot;
    int   pos;
    logic [3:0] nib;
    out_t o;
    slot   = (t / DIV) % 4;
    pos    = t % DIV;
    o.fs   = ((t % FRAME) == FRAME - 1);
    o.ctrl = 4'hF;
    o.disp = 8'hFF;
    if (pos >= blank && en[slot]) begin
      o.ctrl[slot] = 1'b0;
      nib          = 4'(d >> (4 * slot));
      o.disp       = SEG[nib];
      if (dp[slot]) o.disp[7] = 1'b0;
    end
    return o;
  endfunction

  // Reference model: predicts the outputs that follow the next rising edge.
  always @(posedge clk) begin
    #3;
    if (!rst_n) begin
      k_ref   = 0;
      sh_data = 16'h0;
      sh_dp   = 4'h0;
      sh_en   = 4'h0;
      sb_q.delete();
    end else begin
      sb_q.push_back('{a: ref_out(k_ref, sh_data, sh_dp, sh_en, BLANK),
                       b: ref_out(k_ref, sh_data, sh_dp, sh_en, 0)});
      if ((k_ref % FRAME) == FRAME - 1) begin
        sh_data = data_in;
        sh_dp   = dp_in;
        sh_en   = en_in;
      end
      k_ref++;
    end
  end

  // Monitor: every cycle the display presents a new output, compare against the scoreboard.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst_n) begin
      check("rst_ctrl", ctrl_a, 4'hF);
      check("rst_disp", disp_a, 8'hFF);
      check("rst_fs", fs_a, 1'b0);
      check("rst_ctrl_nb", ctrl_b, 4'hF);
    end else if (sb_q.size() == 0) begin
      check("scoreboard_underflow", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check("ctrl", ctrl_a, e.a.ctrl);
      check("disp", disp_a, e.a.disp);
      check("fs", fs_a, e.a.fs);
      check("ctrl_nb", ctrl_b, e.b.ctrl);
      check("disp_nb", disp_b, e.b.disp);
      check("fs_nb", fs_b, e.b.fs);
      check("one_anode_max", ($countones(~ctrl_a) <= 1), 1'b1);
    end
  end

  // Returns at +1 after the edge that raised frame_start; n is the number of edges waited.
  task automatic wait_fs(output int n);
    n = 0;
    for (int i = 1; i <= FRAME + 8; i++) begin
      @(posedge clk);
      #1;
      if (fs_a) begin
        n = i;
        return;
      end
    end
    check("frame_start_timeout", 32'd0, 32'd1);
  endtask

  // Directed check of one full frame on the blanked instance; pack holds slot s in [8s+:8].
  task automatic check_frame(input logic [31:0] pack, input logic [3:0] en_m,
                             input int change_at, input logic [15:0] new_data);
    for (int i = 0; i < FRAME; i++) begin
      int         s;
      int         p;
      logic [3:0] ec;
      logic [7:0] ed;
      s  = i / DIV;
      p  = i % DIV;
      ec = 4'hF;
      ed = 8'hFF;
      if (p >= BLANK && en_m[s]) begin
        ec[s] = 1'b0;
        ed    = pack[8*s +: 8];
      end
      @(posedge clk);
      #1;
      check("frame_ctrl", ctrl_a, ec);
      check("frame_disp", disp_a, ed);
      if (i == change_at) begin
        #1 data_in = new_data;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n   = 1'b0;
    data_in = 16'h0;
    dp_in   = 4'h0;
    en_in   = 4'h0;
    repeat (4) @(posedge clk);
    #2;
    rst_n   = 1'b1;
    data_in = 16'h1A3F;
    en_in   = 4'hF;
    dp_in   = 4'h0;

    // Decode, scan order and frame period, then a mid-slot-1 data change.
    wait_fs(n);
    check("first_fs_after_release", n, FRAME);
    wait_fs(n);
    check("fs_period", n, FRAME);
    check_frame(32'hF9_88_B0_8E, 4'hF, 12, 16'h0000);
    check_frame(32'hC0_C0_C0_C0, 4'hF, -1, 16'h0000);

    // Digit mask and decimal point.
    #1;
    en_in   = 4'b0101;
    dp_in   = 4'b0001;
    data_in = 16'h8888;
    wait_fs(n);
    check_frame(32'hFF_80_FF_00, 4'b0101, -1, 16'h0000);

    // Unblanked instance: one anode low every cycle, switching every DIV cycles.
    #1;
    en_in   = 4'hF;
    dp_in   = 4'($urandom);
    data_in = 16'($urandom);
    wait_fs(n);
    for (int i = 0; i < FRAME; i++) begin
      logic [3:0] ec;
      ec = 4'hF;
      ec[i / DIV] = 1'b0;
      @(posedge clk);
      #1;
      check("nb_anode", ctrl_b, ec);
      check("nb_no_gap", (disp_b != 8'hFF), 1'b1);
    end

    // Sweep every nibble value through digit 0.
    #1;
    for (int v = 0; v < 16; v++) begin
      data_in = {12'($urandom), 4'(v)};
      dp_in   = 4'($urandom);
      en_in   = 4'hF;
      repeat (FRAME) @(posedge clk);
      #2;
    end

    // Random inputs changing at arbitrary points within frames.
    for (int r = 0; r < 14; r++) begin
      repeat ($urandom_range(5, 60)) @(posedge clk);
      #2;
      data_in = 16'($urandom);
      dp_in   = 4'($urandom);
      en_in   = 4'($urandom);
    end

    // Asynchronous reset in the middle of slot 2, then restart from slot 0.
    wait_fs(n);
    repeat (2 * DIV + 3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_ctrl", ctrl_a, 4'hF);
    check("async_rst_disp", disp_a, 8'hFF);
    check("async_rst_fs", fs_a, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n   = 1'b1;
    data_in = 16'hBEEF;
    dp_in   = 4'b1010;
    en_in   = 4'hF;
    wait_fs(n);
    check("restart_fs", n, FRAME);
    check_frame(32'h83_86_86_8E & 32'h7F_FF_7F_FF, 4'hF, -1, 16'hBEEF);

    repeat (2) @(posedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
